cpu_bus_bridge: RTL and testbench

//  Parametrised 68040-style bus slave: second-generation CPU interface.

---
 rtl/cpu_bus_bridge_if.sv | 48 ++++
 rtl/cpu_bus_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_bridge_if.sv
// Pin bundle between cpu_bus_bridge, the 68040-style CPU bus and the memory fabric.
// The bridge uses the slave modport; the CPU/fabric environment uses master.
interface cpu_bus_bridge_if #(
  parameter int AW = 32,
  parameter int LW = 3
);
  logic          cpu_ts_n;
  logic [1:0]    cpu_tt;
  logic [1:0]    cpu_siz;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_data_i;
  logic [31:0]   cpu_data_o;
  logic          cpu_data_oe;
  logic          cpu_ta_n;
  logic          cpu_tea_n;
  logic          cpu_irq_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [3:0]    req_mask;
  logic          req_we;
  logic          write_valid;
  logic [31:0]   write_data;
  logic          read_valid;
  logic [31:0]   read_data;
  logic          read_ack;
  logic          irq_req;
  logic [7:0]    irq_vec;
  logic          irq_ack;

  modport slave (
    input  cpu_ts_n, cpu_tt, cpu_siz, cpu_rw, cpu_addr, cpu_data_i,
    input  req_ready, read_valid, read_data, irq_req, irq_vec,
    output cpu_data_o, cpu_data_oe, cpu_ta_n, cpu_tea_n, cpu_irq_n,
    output req_valid, req_addr, req_len, req_mask, req_we,
    output write_valid, write_data, read_ack, irq_ack
  );

  modport master (
    output cpu_ts_n, cpu_tt, cpu_siz, cpu_rw, cpu_addr, cpu_data_i,
    output req_ready, read_valid, read_data, irq_req, irq_vec,
    input  cpu_data_o, cpu_data_oe, cpu_ta_n, cpu_tea_n, cpu_irq_n,
    input  req_valid, req_addr, req_len, req_mask, req_we,
    input  write_valid, write_data, read_ack, irq_ack
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// 68040-style bus slave: turns CPU TS/TT/SIZ/RW cycles into fabric req/write/read traffic,
// with boot ROM overlay, line bursts, interrupt acknowledge and a bus-timeout TEA path.
module cpu_bus_bridge #(
  parameter int            AW           = 32,
  parameter int            LINE_BEATS   = 4,
  parameter int            LW           = 3,
  parameter int            BOOT_FETCHES = 2,
  parameter logic [AW-1:0] ROM_BASE     = 32'h4000_0000,
  parameter int            ROM_AW       = 16,
  parameter int            TIMEOUT      = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            bus_en_i,
  cpu_bus_bridge_if.slave bus
);
  localparam int BW = (BOOT_FETCHES > 0) ? $clog2(BOOT_FETCHES + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BOOT_MAX = BW'(BOOT_FETCHES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [LW-1:0] LINE_LEN = LW'(LINE_BEATS);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_RD, S_RD_TA, S_WR, S_WR_TA, S_IACK, S_IACK_TA, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [3:0]    mask_q, mask_d;
  logic [LW-1:0] len_q, len_d, beats_q, beats_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   data_o_q, data_o_d, write_data_q, write_data_d;
  logic          data_oe_q, data_oe_d, ta_n_q, ta_n_d, tea_n_q, tea_n_d;
  logic          write_valid_q, write_valid_d, read_ack_q, read_ack_d, irq_ack_q, irq_ack_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic ts_go, accept, rd_beat, tmo_hit, last_beat;
  assign ts_go     = bus_en_i & ~bus.cpu_ts_n;
  assign accept    = req_valid_q & bus.req_ready;
  assign rd_beat   = bus_en_i & bus.read_valid;
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_MAX - 1'b1);
  assign last_beat = (beats_q == LW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (ts_go) begin
                   if (!bus.cpu_tt[1])           state_d = S_REQ;
                   else if (bus.cpu_tt == 2'b11) state_d = S_IACK;
                   else                          state_d = S_ERR;
                 end
      S_REQ:     if (accept)       state_d = rw_q ? S_RD : S_WR;
                 else if (tmo_hit) state_d = S_ERR;
      S_RD:      if (rd_beat)      state_d = S_RD_TA;
                 else if (tmo_hit) state_d = S_ERR;
      S_RD_TA:   if (bus_en_i) state_d = last_beat ? S_IDLE : S_RD;
      S_WR:      if (bus_en_i) state_d = S_WR_TA;
      S_WR_TA:   if (bus_en_i && last_beat) state_d = S_IDLE;
      S_IACK:    if (bus_en_i) state_d = S_IACK_TA;
      S_IACK_TA: if (bus_en_i) state_d = S_IDLE;
      S_ERR:     if (bus_en_i && !tea_n_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d        = addr_q;
    rw_d          = rw_q;
    mask_d        = mask_q;
    len_d         = len_q;
    beats_d       = beats_q;
    req_valid_d   = req_valid_q;
    data_o_d      = data_o_q;
    data_oe_d     = data_oe_q;
    ta_n_d        = ta_n_q;
    tea_n_d       = tea_n_q;
    write_data_d  = write_data_q;
    boot_d        = boot_q;
    tmo_d         = tmo_q;
    write_valid_d = 1'b0;
    read_ack_d    = 1'b0;
    irq_ack_d     = 1'b0;
    unique case (state_q)
      S_IDLE: if (ts_go) begin
        if (!bus.cpu_tt[1]) begin
          rw_d        = bus.cpu_rw;
          req_valid_d = 1'b1;
          tmo_d       = '0;
          len_d       = (bus.cpu_siz == 2'b11) ? LINE_LEN : LW'(1);
          beats_d     = (bus.cpu_siz == 2'b11) ? LINE_LEN : LW'(1);
          unique case (bus.cpu_siz)
            2'b01:   mask_d = 4'b1000 >> bus.cpu_addr[1:0];
            2'b10:   mask_d = bus.cpu_addr[1] ? 4'b0011 : 4'b1100;
            default: mask_d = 4'b1111;
          endcase
          // Early fetches after reset come from the boot ROM window
          if (boot_q < BOOT_MAX) begin
            addr_d = ROM_BASE | AW'(bus.cpu_addr[ROM_AW-1:0]);
            boot_d = boot_q + 1'b1;
          end else begin
            addr_d = bus.cpu_addr;
          end
        end else if (bus.cpu_tt == 2'b11) begin
          data_o_d  = {24'h0, bus.irq_vec};
          irq_ack_d = 1'b1;
        end
      end
      S_REQ: begin
        if (accept) begin
          req_valid_d = 1'b0;
          data_oe_d   = rw_q;
        end else if (tmo_hit) begin
          req_valid_d = 1'b0;
        end
        if (TIMEOUT != 0) tmo_d = tmo_q + 1'b1;
      end
      S_RD: begin
        // A beat arriving in the expiry clock still completes normally
        if (rd_beat) begin
          data_o_d   = bus.read_data;
          read_ack_d = 1'b1;
          ta_n_d     = 1'b0;
          tmo_d      = '0;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RD_TA: if (bus_en_i) begin
        ta_n_d = 1'b1;
        if (last_beat) data_oe_d = 1'b0;
        else           beats_d   = beats_q - 1'b1;
      end
      S_WR: if (bus_en_i) ta_n_d = 1'b0;
      S_WR_TA: if (bus_en_i) begin
        write_data_d  = bus.cpu_data_i;
        write_valid_d = 1'b1;
        if (last_beat) ta_n_d  = 1'b1;
        else           beats_d = beats_q - 1'b1;
      end
      S_IACK: if (bus_en_i) begin
        data_oe_d = 1'b1;
        ta_n_d    = 1'b0;
      end
      S_IACK_TA: if (bus_en_i) begin
        data_oe_d = 1'b0;
        ta_n_d    = 1'b1;
      end
      S_ERR: if (bus_en_i) begin
        if (tea_n_q) begin
          tea_n_d   = 1'b0;
          data_oe_d = 1'b0;
        end else begin
          tea_n_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q        <= '0;
      rw_q          <= 1'b0;
      mask_q        <= '0;
      len_q         <= '0;
      beats_q       <= '0;
      req_valid_q   <= 1'b0;
      data_o_q      <= '0;
      data_oe_q     <= 1'b0;
      ta_n_q        <= 1'b1;
      tea_n_q       <= 1'b1;
      write_valid_q <= 1'b0;
      write_data_q  <= '0;
      read_ack_q    <= 1'b0;
      irq_ack_q     <= 1'b0;
      boot_q        <= '0;
      tmo_q         <= '0;
    end else begin
      addr_q        <= addr_d;
      rw_q          <= rw_d;
      mask_q        <= mask_d;
      len_q         <= len_d;
      beats_q       <= beats_d;
      req_valid_q   <= req_valid_d;
      data_o_q      <= data_o_d;
      data_oe_q     <= data_oe_d;
      ta_n_q        <= ta_n_d;
      tea_n_q       <= tea_n_d;
      write_valid_q <= write_valid_d;
      write_data_q  <= write_data_d;
      read_ack_q    <= read_ack_d;
      irq_ack_q     <= irq_ack_d;
      boot_q        <= boot_d;
      tmo_q         <= tmo_d;
    end
  end

  assign bus.cpu_data_o  = data_o_q;
  assign bus.cpu_data_oe = data_oe_q;
  assign bus.cpu_ta_n    = ta_n_q;
  assign bus.cpu_tea_n   = tea_n_q;
  assign bus.cpu_irq_n   = ~bus.irq_req;
  assign bus.req_valid   = req_valid_q;
  assign bus.req_addr    = addr_q;
  assign bus.req_len     = len_q;
  assign bus.req_mask    = mask_q;
  assign bus.req_we      = ~rw_q;
  assign bus.write_valid = write_valid_q;
  assign bus.write_data  = write_data_q;
  assign bus.read_ack    = read_ack_q;
  assign bus.irq_ack     = irq_ack_q;
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Bench for cpu_bus_bridge: directed bus scenarios plus random CPU cycles, checked against
// a queue-based model of requests, write words, read words and boot-overlay count.
module tb_cpu_bus_bridge;
  localparam int TMO = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic bus_en_i = 1'b0;
  always #5 clk_i = ~clk_i;

  cpu_bus_bridge_if #(.AW(32), .LW(3)) bus ();
  cpu_bus_bridge #(.TIMEOUT(TMO)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus_en_i(bus_en_i), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [2:0]  len;
    logic        we;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  int boot_used = 0;
  bit ready_en = 1'b1;
  bit rv_always = 1'b0;
  bit both_low = 1'b0;
  int ack_cnt = 0, wv_cnt = 0, iack_cnt = 0, last_run = 0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t model_req(input logic [31:0] addr, input logic [1:0] siz, input logic rw);
    logic [3:0] byte_lane[4];
    req_t r;
    byte_lane = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    r.len  = (siz == 2'b11) ? 3'd4 : 3'd1;
    r.we   = ~rw;
    r.mask = (siz == 2'b01) ? byte_lane[addr[1:0]] :
             (siz == 2'b10) ? ((addr[1]) ? 4'b0011 : 4'b1100) : 4'b1111;
    r.addr = addr;
    if (boot_used < 2) begin
      r.addr = 32'h4000_0000 | (addr & 32'h0000_FFFF);
      boot_used++;
    end
    return r;
  endfunction

  // Memory fabric: checks requests and write words, serves read words, counts pulses.
  initial begin
    logic pv, pr;
    int run, rd_left;
    logic [31:0] word;
    req_t r;
    pv = 0; pr = 0; run = 0; rd_left = 0; word = $urandom;
    bus.req_ready = 0; bus.read_valid = 0; bus.read_data = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_req.delete(); exp_wr.delete(); exp_rd.delete();
        pv = 0; pr = 0; run = 0; rd_left = 0;
        bus.req_ready = 0; bus.read_valid = 0;
      end else begin
        if (!bus.cpu_ta_n && !bus.cpu_tea_n) both_low = 1'b1;
        if (pv && pr && !r.we) rd_left += int'(r.len);
        if (bus.req_valid) begin
          if (run == 0) begin
            if (exp_req.size() == 0) chk("req_unexpected", 64'(bus.req_valid), 64'd0);
            else begin
              r = exp_req.pop_front();
              chk("req_addr", 64'(bus.req_addr), 64'(r.addr));
              chk("req_mask", 64'(bus.req_mask), 64'(r.mask));
              chk("req_len",  64'(bus.req_len),  64'(r.len));
              chk("req_we",   64'(bus.req_we),   64'(r.we));
            end
          end
          run++;
        end else begin
          if (run != 0) last_run = run;
          run = 0;
        end
        if (bus.read_ack) begin
          ack_cnt++;
          exp_rd.push_back(word);
          word = $urandom;
          rd_left--;
        end
        if (bus.write_valid) begin
          wv_cnt++;
          if (exp_wr.size() == 0) chk("write_unexpected", 64'(bus.write_valid), 64'd0);
          else chk("write_data", 64'(bus.write_data), 64'(exp_wr.pop_front()));
        end
        if (bus.irq_ack) iack_cnt++;
        bus.req_ready  = ready_en && ($urandom_range(3) != 0);
        bus.read_data  = word;
        bus.read_valid = (rd_left > 0) && (rv_always || ($urandom_range(7) != 0));
        pv = bus.req_valid;
        pr = bus.req_ready;
      end
    end
  end

  // One CPU bus edge: strobe high for a single clk, TS released afterwards.
  task automatic strobe();
    bus_en_i = 1'b1;
    @(negedge clk_i);
    bus_en_i = 1'b0;
    bus.cpu_ts_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic cpu_xfer(input logic [1:0] tt, input logic [1:0] siz, input logic rw,
                          input logic [31:0] addr, input bit tmo);
    logic [31:0] wd[8];
    logic [31:0] vec;
    int len, beats, tas, teas, a0, w0, i0, budget;
    bit mem, exp_tea;
    mem = !tt[1];
    exp_tea = (tt == 2'b10) || tmo;
    len = (mem && siz == 2'b11) ? 4 : 1;
    a0 = ack_cnt; w0 = wv_cnt; i0 = iack_cnt;
    for (int i = 0; i < 8; i++) wd[i] = $urandom;
    vec = {24'h0, bus.irq_vec};
    if (mem) begin
      exp_req.push_back(model_req(addr, siz, rw));
      if (!rw && !tmo) for (int i = 0; i < len; i++) exp_wr.push_back(wd[i]);
    end
    bus.cpu_ts_n = 1'b0; bus.cpu_tt = tt; bus.cpu_siz = siz; bus.cpu_rw = rw; bus.cpu_addr = addr;
    strobe();
    beats = 0; tas = 0; teas = 0;
    for (budget = 0; budget < 100 && beats < len && teas == 0; budget++) begin
      bus.cpu_data_i = wd[beats];
      if (!bus.cpu_ta_n) begin
        tas++;
        if (tt == 2'b11) begin
          chk("iack_vector", 64'(bus.cpu_data_o), 64'(vec));
          chk("iack_oe", 64'(bus.cpu_data_oe), 64'd1);
        end else if (rw) begin
          chk("read_oe", 64'(bus.cpu_data_oe), 64'd1);
          if (exp_rd.size() == 0) chk("read_missing", 64'd1, 64'd0);
          else chk("read_data", 64'(bus.cpu_data_o), 64'(exp_rd.pop_front()));
        end
        beats++;
      end
      if (!bus.cpu_tea_n) teas++;
      strobe();
    end
    chk("ta_cycles", 64'(tas), exp_tea ? 64'd0 : 64'(len));
    chk("tea_cycles", 64'(teas), exp_tea ? 64'd1 : 64'd0);
    chk("idle_pins", 64'({bus.cpu_ta_n, bus.cpu_tea_n, bus.cpu_data_oe}), 64'b110);
    if (mem && rw)   chk("read_acks", 64'(ack_cnt - a0), tmo ? 64'd0 : 64'(len));
    if (mem && !rw)  chk("write_pulses", 64'(wv_cnt - w0), tmo ? 64'd0 : 64'(len));
    if (tt == 2'b11) chk("irq_acks", 64'(iack_cnt - i0), 64'd1);
  endtask

  initial begin
    logic [31:0] wd[4];
    int w0;
    bit seen;
    logic [1:0] tt;
    bus.cpu_ts_n = 1; bus.cpu_tt = 0; bus.cpu_siz = 0; bus.cpu_rw = 1; bus.cpu_addr = 0;
    bus.cpu_data_i = 0; bus.irq_req = 0; bus.irq_vec = 0;
    repeat (3) @(negedge clk_i);
    chk("reset_pins", 64'({bus.cpu_ta_n, bus.cpu_tea_n, bus.cpu_data_oe, bus.req_valid,
                           bus.write_valid, bus.read_ack, bus.irq_ack}), 64'b1100000);
    chk("reset_data_o", 64'(bus.cpu_data_o), 64'd0);
    rst_i = 0;
    @(negedge clk_i);

    // Boot overlay on first two accesses, then long byte write, line read, IACK
    repeat (3) cpu_xfer(2'b00, 2'b00, 1'b1, 32'h0000_1234, 0);
    cpu_xfer(2'b00, 2'b01, 1'b0, 32'h0000_0003, 0);
    rv_always = 1;
    cpu_xfer(2'b00, 2'b11, 1'b1, 32'h0000_8000, 0);
    rv_always = 0;
    bus.irq_vec = 8'h45;
    cpu_xfer(2'b11, 2'b00, 1'b1, 32'h0, 0);

    bus.irq_req = 1; #1 chk("irq_n_on", 64'(bus.cpu_irq_n), 64'd0);
    bus.irq_req = 0; #1 chk("irq_n_off", 64'(bus.cpu_irq_n), 64'd1);
    @(negedge clk_i);

    // Fabric never accepts: timeout then TEA
    ready_en = 0;
    cpu_xfer(2'b00, 2'b00, 1'b1, 32'h0000_0040, 1);
    chk("tmo_req_cycles", 64'(last_run), 64'(TMO));
    ready_en = 1;
    cpu_xfer(2'b10, 2'b00, 1'b1, 32'h0000_0044, 0);

    // Reset in the middle of a line write
    w0 = wv_cnt;
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    exp_req.push_back(model_req(32'h0000_2000, 2'b11, 1'b0));
    for (int i = 0; i < 4; i++) exp_wr.push_back(wd[i]);
    bus.cpu_ts_n = 0; bus.cpu_tt = 2'b00; bus.cpu_siz = 2'b11; bus.cpu_rw = 0; bus.cpu_addr = 32'h2000;
    strobe();
    seen = 0;
    for (int b = 0; b < 50 && !seen; b++) begin
      bus.cpu_data_i = wd[0];
      seen = !bus.cpu_ta_n;
      strobe();
    end
    chk("mid_write_ta", 64'(seen), 64'd1);
    chk("mid_write_ta_low", 64'(bus.cpu_ta_n), 64'd0);
    rst_i = 1;
    #1;
    chk("async_reset_pins", 64'({bus.cpu_ta_n, bus.cpu_tea_n, bus.cpu_data_oe, bus.req_valid,
                                 bus.write_valid, bus.read_ack, bus.irq_ack}), 64'b1100000);
    chk("async_reset_data_o", 64'(bus.cpu_data_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    boot_used = 0;
    @(negedge clk_i);
    chk("mid_write_pulses", 64'(wv_cnt - w0), 64'd1);
    cpu_xfer(2'b00, 2'b00, 1'b1, 32'h0012_5678, 0);

    // Random CPU cycles
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(9) < 7) tt = 2'($urandom_range(1));
      else                       tt = ($urandom_range(1) != 0) ? 2'b10 : 2'b11;
      bus.irq_vec = 8'($urandom);
      cpu_xfer(tt, 2'($urandom_range(3)), 1'($urandom_range(1)), $urandom, 0);
    end

    chk("ta_tea_overlap", 64'(both_low), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
